// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - 4-digit BCD up/down stopwatch counter with prescaled step
module stopwatch_counter #(
    parameter int TICK_DIV = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  current_state,
    input  logic [15:0] timeout,
    input  logic        clear,
    output logic [15:0] count,
    output logic        done,
    output logic        overflow,
    output logic        running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        UP_WAIT   = 2'b00,
        UP_RUN    = 2'b01,
        DOWN_WAIT = 2'b10,
        DOWN_RUN  = 2'b11
    } sw_state_t;

    sw_state_t       state;
    logic [PW-1:0]   prescaler;
    logic [1:0]      prev_state;
    logic            run_state;
    logic            step;
    logic [15:0]     count_next;
    logic            wrap;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  d;
        logic        carry;
        r = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[i*4 +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    d = 4'd0;
                end else begin
                    d = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  d;
        logic        borrow;
        r = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[i*4 +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = 4'd9;
                end else begin
                    d = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    // Non-decimal preset digits saturate at 9 so the display never shows A-F.
    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        end
        return r;
    endfunction

    assign state     = sw_state_t'(current_state);
    assign run_state = current_state[0];
    assign step      = run_state && (prescaler == PRE_MAX);

    always_comb begin
        count_next = count;
        wrap       = 1'b0;
        if (clear) begin
            count_next = 16'h0000;
        end else begin
            case (state)
                UP_WAIT: begin
                    if (prev_state[1]) begin
                        count_next = 16'h0000;
                    end
                end
                UP_RUN: begin
                    if (step) begin
                        count_next = bcd_inc(count);
                        wrap       = (count == 16'h9999);
                    end
                end
                DOWN_WAIT: begin
                    count_next = bcd_sanitize(timeout);
                end
                DOWN_RUN: begin
                    if (step && (count != 16'h0000)) begin
                        count_next = bcd_dec(count);
                    end
                end
                default: begin
                    count_next = count;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            prev_state <= 2'b00;
            count      <= 16'h0000;
            done       <= 1'b0;
            overflow   <= 1'b0;
            running    <= 1'b0;
        end else begin
            // Leaving run discards partial progress so a resume waits a full interval.
            if (clear || !run_state || step) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            prev_state <= current_state;
            count      <= count_next;
            done       <= (state == DOWN_RUN) && (count_next == 16'h0000);
            overflow   <= wrap;
            running    <= run_state;
        end
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter: TICK_DIV, default 1000000, clk cycles per count step (10 ms at 100 MHz); legal range is 2 or greater.
REQ-002 Port: clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: current_state  input  2  stopwatch state code: 00 up_wait, 01 up_run, 10 down_wait, 11 down_run.
REQ-005 Port: timeout  input  16  4-digit BCD countdown preset; [15:12] is the most significant digit.
REQ-006 Port: clear  input  1  one-cycle pulse that clears the count (clear-switch edge).
REQ-007 Port: count  output  16  4-digit BCD value for display, registered.
REQ-008 Port: done  output  1  high while a countdown sits at 0000 in down_run, registered.
REQ-009 Port: overflow  output  1  one-cycle pulse when the up count wraps from 9999 to 0000, registered.
REQ-010 Port: running  output  1  high while current_state is 01 or 11, registered.

Function
REQ-011 The block SHALL hold a prescaler of width ceil(log2(TICK_DIV)) that counts 0..TICK_DIV-1 only in run states and is forced to 0 in wait states.
- Internal step = prescaler at TICK_DIV-1.
- On a step the prescaler wraps to 0 on the same edge.
REQ-012 The block SHALL register current_state as prev_state every cycle so that family changes (up vs down) are detected.
REQ-013 up_wait: count SHALL hold.
- Exception: when prev_state was 10 or 11, count SHALL load 0000 (mode-change clear).
REQ-014 up_run: on each step, count SHALL increment as a 4-digit BCD value with digit-wise carry (xxx9 -> xx(x+1)0).
- 9999 SHALL wrap to 0000.
- overflow SHALL pulse high for exactly the cycle following the wrap edge.
REQ-015 down_wait: count SHALL load the sanitised timeout every cycle; any digit above 9 loads as 9.
REQ-016 down_run: on each step with count not equal to 0000, count SHALL decrement as BCD with digit-wise borrow (x0 -> (x-1)9).
REQ-017 down_run with count equal to 0000: count SHALL hold 0000, no further decrement, and done SHALL be 1.
- If count is already 0000 on entry, done rises one cycle after entry with no step.
REQ-018 done SHALL be 0 in every state other than down_run.
REQ-019 clear SHALL force count to 0000 and the prescaler to 0 on the next edge in any state.
- In down_wait, a clear loads 0000 for that cycle only; timeout reloads on the following cycle.
REQ-020 When clear and a step occur in the same cycle, clear SHALL win: no increment, no decrement, no overflow.
REQ-021 Latency SHALL be one clk from a step, clear or state change to the updated count/done/running; there is no combinational input-to-output path.
REQ-022 A run -> wait transition mid-count SHALL freeze count at its current value and discard prescaler progress.
- Resuming run restarts a full TICK_DIV interval.
REQ-023 Only count digits 0-9 SHALL ever be produced; the BCD arithmetic is on 4-bit digits and never uses a binary carry across a digit.

Reset
REQ-024 While reset is high at a clk edge, the block SHALL set: count 0000, done 0, overflow 0, running 0, prescaler 0, prev_state 00.
REQ-025 reset SHALL have priority over clear, steps and every state input, including mid-run.
REQ-026 After reset deasserts, operation SHALL resume from the reset values according to current_state on the next edge.

Verification (TICK_DIV=4)
REQ-027 Up count: reset, then up_run for 40 cycles -> count 0010; first increment 4 cycles after entry; running=1.
REQ-028 Up wrap: drive up_run from count 9999 (reach it via clear-free run) -> next step gives 0000 and overflow high for exactly 1 cycle.
REQ-029 Down with borrow: down_wait with timeout=0100, then down_run -> count goes 0099, 0098, ... one step per 4 cycles.
- After 100 steps: count 0000, done=1, count then holds.
REQ-030 Boundaries:
- timeout=00A0 in down_wait -> count 0090.
- down_run entered with timeout=0000 -> done=1 next cycle, count unchanged.
REQ-031 Priority:
- clear coincident with a step in up_run -> count 0000, no overflow.
- down_run -> up_wait transition -> count 0000, done=0.
- reset asserted mid up_run -> all outputs at reset values next edge.
